// File: rtl/piezo_tune_seq_if.sv
// piezo_tune_seq_if: control-side handshake and piezo-counter drive bundle for the fanfare sequencer
interface piezo_tune_seq_if;
    logic        start;
    logic        abort;
    logic [14:0] note_per;
    logic        clr;
    logic        busy;
    logic        done;
    logic [2:0]  note_idx;
    modport master (output start, abort, input note_per, clr, busy, done, note_idx);
    modport slave  (input start, abort, output note_per, clr, busy, done, note_idx);
endinterface

// File: rtl/piezo_tune_seq.sv
// piezo_tune_seq: plays a fixed six-note fanfare by driving period/clear into the piezo frequency counter
module piezo_tune_seq #(
    parameter int UNIT_LOG2 = 22,
    parameter int GAP_LOG2  = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    piezo_tune_seq_if.slave   bus
);
    localparam int TW = UNIT_LOG2 + 4;

    typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

    state_t          r_state;
    logic [TW-1:0]   r_timer;
    logic [2:0]      r_idx;
    logic            r_done;
    logic [14:0]     r_note_per;
    logic            r_clr;
    logic            r_busy;
    logic            w_note_end;
    logic            w_gap_end;

    function automatic logic [14:0] f_per(input logic [2:0] idx);
        case (idx)
            3'd0:    return 15'd31888;
            3'd1:    return 15'd23889;
            3'd2:    return 15'd18961;
            3'd3:    return 15'd15944;
            3'd4:    return 15'd18961;
            default: return 15'd15944;
        endcase
    endfunction

    function automatic logic [3:0] f_dur(input logic [2:0] idx);
        case (idx)
            3'd3:    return 4'd3;
            3'd4:    return 4'd1;
            3'd5:    return 4'd8;
            default: return 4'd2;
        endcase
    endfunction

    assign w_note_end = r_timer == {f_dur(r_idx), {UNIT_LOG2{1'b0}}} - TW'(1);
    assign w_gap_end  = r_timer == TW'((1 << GAP_LOG2) - 1);

    // Sequencer FSM; outputs are registered alongside the state they belong to
    always_ff @(posedge clk) begin
        if (!rst_n || bus.abort) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_idx      <= '0;
            r_done     <= 1'b0;
            r_note_per <= '0;
            r_clr      <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state    <= NOTE;
                        r_timer    <= '0;
                        r_idx      <= '0;
                        r_note_per <= f_per(3'd0);
                        r_clr      <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                NOTE: begin
                    if (w_note_end) begin
                        r_state    <= GAP;
                        r_timer    <= '0;
                        r_note_per <= '0;
                        r_clr      <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                GAP: begin
                    if (!w_gap_end) begin
                        r_timer <= r_timer + TW'(1);
                    end else if (r_idx == 3'd5) begin
                        r_state <= IDLE;
                        r_timer <= '0;
                        r_idx   <= '0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state    <= NOTE;
                        r_timer    <= '0;
                        r_idx      <= r_idx + 3'd1;
                        r_note_per <= f_per(r_idx + 3'd1);
                        r_clr      <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_timer    <= '0;
                    r_idx      <= '0;
                    r_note_per <= '0;
                    r_clr      <= 1'b1;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.note_per = r_note_per;
    assign bus.clr      = r_clr;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.note_idx = r_idx;
endmodule

// File: tb/tb_piezo_tune_seq.sv
// tb_piezo_tune_seq: scoreboard bench comparing every cycle against a tune-position reference model
module tb_piezo_tune_seq;
    localparam int UL   = 4;
    localparam int GL   = 2;
    localparam int UNIT = 1 << UL;
    localparam int GAP  = 1 << GL;
    localparam int TUNE = 18 * UNIT + 6 * GAP;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    piezo_tune_seq_if bus();

    piezo_tune_seq #(.UNIT_LOG2(UL), .GAP_LOG2(GL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int dur [6] = '{2, 2, 2, 3, 1, 8};
    int per [6] = '{31888, 23889, 18961, 15944, 18961, 15944};

    logic [21:0] q [$];
    logic [21:0] e_v, a_v;
    int n_cmp = 0;
    int n_bad = 0;

    bit m_play = 0;
    bit m_done = 0;
    int t      = 0;

    // Expected outputs from the position within the tune: {note_per, clr, busy, done, note_idx}
    function automatic logic [21:0] exp_out();
        int pos;
        if (!m_play) return {15'd0, 1'b1, 1'b0, m_done, 3'd0, 1'b0};
        pos = t;
        for (int i = 0; i < 6; i++) begin
            if (pos < dur[i] * UNIT) return {15'(per[i]), 1'b0, 1'b1, 1'b0, 3'(i), 1'b0};
            pos -= dur[i] * UNIT;
            if (pos < GAP) return {15'd0, 1'b1, 1'b1, 1'b0, 3'(i), 1'b0};
            pos -= GAP;
        end
        return '1;
    endfunction

    // One clock of stimulus; the model advances with the same sampled inputs
    task automatic cyc(input bit s, input bit a, input bit r);
        bus.start = s;
        bus.abort = a;
        rst_n     = r;
        @(posedge clk);
        #1;
        if (!r || a) begin
            m_play = 0;
            m_done = 0;
        end else if (m_play) begin
            t++;
            m_done = 0;
            if (t == TUNE) begin
                m_play = 0;
                m_done = 1;
            end
        end else begin
            m_done = 0;
            if (s) begin
                m_play = 1;
                t = 0;
            end
        end
        q.push_back(exp_out());
    endtask

    // Monitor: pop one expectation per cycle, away from the active edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e_v = q.pop_front();
            a_v = {bus.note_per, bus.clr, bus.busy, bus.done, bus.note_idx, 1'b0};
            n_cmp++;
            if (a_v !== e_v) begin
                n_bad++;
                $display("FAIL outputs @%0t: got per=%0d clr=%b busy=%b done=%b idx=%0d, want per=%0d clr=%b busy=%b done=%b idx=%0d",
                         $time, a_v[21:7], a_v[6], a_v[5], a_v[4], a_v[3:1],
                         e_v[21:7], e_v[6], e_v[5], e_v[4], e_v[3:1]);
            end
        end
    end

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        rst_n     = 1'b0;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        repeat (10) cyc(0, 0, 1);
        // full undisturbed tune
        cyc(1, 0, 1);
        for (int i = 1; i <= TUNE + 5; i++) cyc(0, 0, 1);
        // abort in the middle of note 2
        cyc(1, 0, 1);
        for (int i = 1; i < 80; i++) cyc(0, 0, 1);
        cyc(0, 1, 1);
        repeat (400) cyc(0, 0, 1);
        // start pulses while busy, in a gap and during note 1, plus random extras
        cyc(1, 0, 1);
        for (int i = 1; i < TUNE; i++) cyc(i == 33 || i == 40 || $urandom_range(0, 15) == 0, 0, 1);
        repeat (6) cyc(0, 0, 1);
        // start with abort in idle, then start held high
        repeat (3) cyc(1, 1, 1);
        repeat (2 * (TUNE + 1) + 20) cyc(1, 0, 1);
        repeat (3) cyc(0, 0, 1);
        // reset inside the gap after note 4, then a fresh tune
        cyc(1, 0, 1);
        for (int i = 1; i < 177; i++) cyc(0, 0, 1);
        cyc(0, 0, 0);
        repeat (5) cyc(0, 0, 1);
        cyc(1, 0, 1);
        for (int i = 1; i <= TUNE + 5; i++) cyc(0, 0, 1);
        // random stress
        repeat (1500) cyc($urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0, $urandom_range(0, 299) != 0);
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
